// File: rtl/gcd_sched.sv
// gcd_sched: round-robin arbiter sharing one GCD engine among N_REQ requesters.
// Optional engine watchdog enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_sched #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TMO_CYC = 255
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         REQ_VALID,
    output logic [N_REQ-1:0]         REQ_READY,
    input  logic [N_REQ*W-1:0]       REQ_A,
    input  logic [N_REQ*W-1:0]       REQ_B,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [$clog2(N_REQ)-1:0] RSP_ID,
    output logic [W-1:0]             RSP_Y,
    output logic                     RSP_ERROR,
    output logic                     RSP_TMO,
    output logic                     ENG_START,
    output logic [W-1:0]             ENG_A,
    output logic [W-1:0]             ENG_B,
    input  logic [W-1:0]             ENG_Y,
    input  logic                     ENG_DONE,
    input  logic                     ENG_ERROR,
    output logic [15:0]              OP_COUNT
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr, gnt, id;
    logic          found;
    logic [W-1:0]  op_a, op_b, rsp_y;
    logic          rsp_err;
    logic [15:0]   op_cnt;

    // Scan downward so the nearest valid requester after ptr is the last (winning) assignment.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (REQ_VALID[IW'((int'(ptr) + k) % N_REQ)]) begin
                gnt   = IW'((int'(ptr) + k) % N_REQ);
                found = 1'b1;
            end
        end
    end

    assign REQ_READY = (RST_N && state == IDLE && found) ? (N_REQ'(1) << gnt) : '0;
    assign ENG_START = state == ISSUE;
    assign RSP_VALID = state == RESP;
    assign ENG_A     = op_a;
    assign ENG_B     = op_b;
    assign RSP_ID    = id;
    assign RSP_Y     = rsp_y;
    assign RSP_ERROR = rsp_err;
    assign OP_COUNT  = op_cnt;

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt;
    logic          rsp_tmo;
    assign RSP_TMO = rsp_tmo;
`else
    assign RSP_TMO = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            ptr     <= IW'(N_REQ - 1);
            id      <= '0;
            op_a    <= '0;
            op_b    <= '0;
            rsp_y   <= '0;
            rsp_err <= 1'b0;
            op_cnt  <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
            cnt     <= '0;
            rsp_tmo <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a  <= REQ_A[int'(gnt)*W +: W];
                    op_b  <= REQ_B[int'(gnt)*W +: W];
                    id    <= gnt;
                    ptr   <= gnt;
                    state <= ISSUE;
                end
                ISSUE: begin
`ifdef GCD_SCHED_TIMEOUT_EN
                    cnt     <= '0;
                    rsp_tmo <= 1'b0;
`endif
                    state <= WAIT;
                end
                WAIT: if (ENG_DONE) begin
                    rsp_y   <= ENG_Y;
                    rsp_err <= ENG_ERROR;
                    state   <= RESP;
                end
`ifdef GCD_SCHED_TIMEOUT_EN
                // Limit is hit on the cycle whose increment would reach TMO_CYC.
                else if (cnt == CW'(TMO_CYC - 1)) begin
                    rsp_y   <= '0;
                    rsp_err <= 1'b1;
                    rsp_tmo <= 1'b1;
                    state   <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                RESP: if (RSP_READY) begin
                    op_cnt <= op_cnt + 16'd1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
